// File: rtl/zigbee_uart_rx.sv
// zigbee_uart_rx: 8N1 serial receiver for the Zigbee radio link.
// Synchronises rx, qualifies the start bit at half-bit, samples each data bit
// mid-bit (LSB first) and checks the stop bit. Only correctly framed bytes
// reach receiveData, announced by a one-cycle receive strobe.
module zigbee_uart_rx #(
   parameter int          CLK_HZ     = 50_000_000,
   parameter int          BAUD       = 9600,
   parameter int          OVERSAMPLE = 16,
   parameter logic [7:0]  RESET_DATA = 8'hC0
) (
   input  logic       clk_50M,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] receiveData,
   output logic       receive,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TCK_W = $clog2(OVERSAMPLE) + 1;

   localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(DIV - 1);
   localparam logic [TCK_W-1:0] HALF_M1 = TCK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TCK_W-1:0] FULL_M1 = TCK_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t             state;
   logic               rx_m;
   logic               rx_s;
   logic [DIV_W-1:0]   div_cnt;
   logic [TCK_W-1:0]   tick_cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
   logic               tick;

   // Two-flop synchroniser; both flops reset to the idle (high) line level.
   always_ff @(posedge clk_50M) begin
      // NOTE: non-blocking assignments make rx_s see last cycle's rx_m, giving two real stages.
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   assign tick = (div_cnt == DIV_M1);

   // Oversample divider; held clear in IDLE so the sample phase locks to the start edge.
   always_ff @(posedge clk_50M) begin
      if (rst || state == IDLE) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Receive FSM with registered data, strobes and busy.
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         receiveData <= RESET_DATA;
         receive     <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         // NOTE: strobes default low here so each is a single-cycle pulse wherever it is set below.
         receive   <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (!rx_s) begin
                  tick_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (tick_cnt == HALF_M1) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        bit_idx <= '0;
                        state   <= DATA;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (tick_cnt == FULL_M1) begin
                     tick_cnt       <= '0;
                     shift[bit_idx] <= rx_s;
                     if (bit_idx == 3'd7) begin
                        state <= STOP;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (tick_cnt == FULL_M1) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        receiveData <= shift;
                        receive     <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= BRK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            BRK: begin
               if (rx_s) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
